// File: rtl/display_src_arbiter_if.sv
// Channel-to-display bundle between the source blocks and the display arbiter.
// Latency: none (wires only).
// Backpressure: none; ch_valid is a level "ready" flag, outputs are registered by the arbiter.
interface display_src_arbiter_if #(
  parameter int N_CH = 3,
  parameter int W    = 16
);
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH*W-1:0] ch_data;
  logic [N_CH-1:0]   ch_valid;
  logic [W-1:0]      numero_output;
  logic [SW-1:0]     sel_o;
  logic              blank_o;
  logic              changed_o;

  // Source side: drives channel data/flags, observes the display state.
  modport master (
    output ch_data, ch_valid,
    input  numero_output, sel_o, blank_o, changed_o
  );

  // Arbiter side.
  modport slave (
    input  ch_data, ch_valid,
    output numero_output, sel_o, blank_o, changed_o
  );
endinterface

// File: rtl/display_src_arbiter.sv
// Picks which channel drives the BCD/7-segment path, with min hold, blank gap and change strobe.
// Latency: 1 cycle from ch_data[sel] to numero_output in SHOW; switches take BLANK_CYC+1 edges.
// Backpressure: none; channels are level-qualified by ch_valid, the display never stalls them.
module display_src_arbiter #(
  parameter int N_CH      = 3,
  parameter int W         = 16,
  parameter int HOLD_CYC  = 4,
  parameter int BLANK_CYC = 2,
  parameter int LIVE      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  display_src_arbiter_if.slave  bus
);

  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYC);
  localparam logic [BW-1:0] BLANK_LD = (BLANK_CYC > 0) ? BW'(BLANK_CYC - 1) : '0;

  typedef enum logic {
    S_SHOW  = 1'b0,
    S_BLANK = 1'b1
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_sel;
  logic [HW-1:0] r_hold;
  logic [BW-1:0] r_blank_cnt;
  logic [W-1:0]  r_out;
  logic          r_blank_o;
  logic          r_changed;

  state_t        w_state;
  logic [SW-1:0] w_sel;
  logic [HW-1:0] w_hold;
  logic [BW-1:0] w_blank_cnt;
  logic [W-1:0]  w_out;
  logic          w_blank_o;
  logic          w_changed;

  logic [SW-1:0] w_cand;
  logic          w_switch;
  logic [W-1:0]  w_ch [N_CH];

  // Channel 0 is the always-eligible base, so its valid flag carries no information.
  logic w_unused_valid0;
  assign w_unused_valid0 = bus.ch_valid[0];

  // Split the packed channel bus into one word per channel.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_ch[i] = bus.ch_data[i*W +: W];
    end
  end

  // Candidate: highest-index valid channel above 0, falling back to the base channel.
  always_comb begin
    w_cand = '0;
    for (int i = 1; i < N_CH; i++) begin
      if (bus.ch_valid[i]) begin
        w_cand = SW'(i);
      end
    end
  end

  // Higher priority preempts the hold; a lower one must wait for the hold to expire.
  assign w_switch = (w_cand != r_sel) && ((w_cand > r_sel) || (r_hold == '0));

  // Next-state and next-output logic for the SHOW/BLANK controller.
  always_comb begin
    w_state     = r_state;
    w_sel       = r_sel;
    w_hold      = r_hold;
    w_blank_cnt = r_blank_cnt;
    w_out       = r_out;
    w_blank_o   = r_blank_o;
    w_changed   = 1'b0;

    case (r_state)
      S_SHOW: begin
        w_blank_o = 1'b0;
        if (r_hold != '0) begin
          w_hold = r_hold - HW'(1);
        end
        if (LIVE != 0) begin
          w_out = w_ch[r_sel];
        end
        if (w_switch) begin
          w_sel = w_cand;
          if (BLANK_CYC > 0) begin
            w_state     = S_BLANK;
            w_blank_cnt = BLANK_LD;
            w_out       = '0;
            w_blank_o   = 1'b1;
          end else begin
            // No gap: load the new source directly and restart the hold.
            w_out     = w_ch[w_cand];
            w_hold    = HOLD_LD;
            w_changed = 1'b1;
          end
        end
      end

      S_BLANK: begin
        w_out     = '0;
        w_blank_o = 1'b1;
        if (r_blank_cnt == '0) begin
          // Only the candidate present at the end of the gap is used.
          w_state   = S_SHOW;
          w_sel     = w_cand;
          w_out     = w_ch[w_cand];
          w_hold    = HOLD_LD;
          w_blank_o = 1'b0;
          w_changed = 1'b1;
        end else begin
          w_blank_cnt = r_blank_cnt - BW'(1);
        end
      end
    endcase
  end

  // State and output registers; reset puts the base channel on display with no hold pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_SHOW;
      r_sel       <= '0;
      r_hold      <= '0;
      r_blank_cnt <= '0;
      r_out       <= '0;
      r_blank_o   <= 1'b0;
      r_changed   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sel       <= w_sel;
      r_hold      <= w_hold;
      r_blank_cnt <= w_blank_cnt;
      r_out       <= w_out;
      r_blank_o   <= w_blank_o;
      r_changed   <= w_changed;
    end
  end

  assign bus.numero_output = r_out;
  assign bus.sel_o         = r_sel;
  assign bus.blank_o       = r_blank_o;
  assign bus.changed_o     = r_changed;

endmodule

// File: tb/tb_display_src_arbiter.sv
// Bench for display_src_arbiter: live and frozen instances driven with identical stimulus.
// Latency: reference model is updated per clock edge and compared 1 ns after it.
// Backpressure: not applicable; inputs are free-running levels.
module tb_display_src_arbiter;

  localparam int HOLD  = 4;
  localparam int BLANK = 2;

  logic        clk;
  logic        rst;
  logic [47:0] data;
  logic [2:0]  valid;

  int total = 0;
  int bad   = 0;

  display_src_arbiter_if #(.N_CH(3), .W(16)) if_live ();
  display_src_arbiter_if #(.N_CH(3), .W(16)) if_frz ();

  assign if_live.ch_data  = data;
  assign if_live.ch_valid = valid;
  assign if_frz.ch_data   = data;
  assign if_frz.ch_valid  = valid;

  display_src_arbiter #(.N_CH(3), .W(16), .HOLD_CYC(HOLD), .BLANK_CYC(BLANK), .LIVE(1)) dut_live (
    .clk (clk),
    .rst (rst),
    .bus (if_live)
  );

  display_src_arbiter #(.N_CH(3), .W(16), .HOLD_CYC(HOLD), .BLANK_CYC(BLANK), .LIVE(0)) dut_frz (
    .clk (clk),
    .rst (rst),
    .bus (if_frz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, index 0 = live instance, 1 = frozen instance.
  // age counts SHOW edges since the source was shown; a lower-priority switch needs age >= HOLD.
  int          m_sel   [2];
  int          m_age   [2];
  int          m_bdone [2];
  bit          m_blank [2];
  bit          m_bo    [2];
  bit          m_chg   [2];
  logic [15:0] m_out   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_sel[k]   = 0;
    m_age[k]   = HOLD;
    m_bdone[k] = 0;
    m_blank[k] = 0;
    m_bo[k]    = 0;
    m_chg[k]   = 0;
    m_out[k]   = 16'h0;
  endtask

  task automatic model_step(input int k, input bit live, input logic rst_now,
                            input logic [47:0] d, input logic [2:0] v);
    int          cand;
    logic [15:0] ch [3];
    ch[0] = d[15:0];
    ch[1] = d[31:16];
    ch[2] = d[47:32];
    if (!rst_now) begin
      model_reset(k);
      return;
    end
    cand = 0;
    for (int i = 1; i < 3; i++) if (v[i]) cand = i;
    m_chg[k] = 0;
    if (m_blank[k]) begin
      if (m_bdone[k] == BLANK - 1) begin
        m_blank[k] = 0;
        m_bo[k]    = 0;
        m_sel[k]   = cand;
        m_out[k]   = ch[cand];
        m_chg[k]   = 1;
        m_age[k]   = 0;
      end else begin
        m_bdone[k]++;
      end
    end else if (cand != m_sel[k] && (cand > m_sel[k] || m_age[k] >= HOLD)) begin
      m_sel[k] = cand;
      if (BLANK > 0) begin
        m_blank[k] = 1;
        m_bo[k]    = 1;
        m_bdone[k] = 0;
        m_out[k]   = 16'h0;
      end else begin
        m_out[k] = ch[cand];
        m_age[k] = 0;
        m_chg[k] = 1;
      end
    end else begin
      if (live) m_out[k] = ch[m_sel[k]];
      if (m_age[k] < HOLD) m_age[k]++;
    end
  endtask

  task automatic check_all();
    chk("live_out",   32'(if_live.numero_output), 32'(m_out[0]));
    chk("live_sel",   32'(if_live.sel_o),         32'(m_sel[0]));
    chk("live_blank", 32'(if_live.blank_o),       32'(m_bo[0]));
    chk("live_chg",   32'(if_live.changed_o),     32'(m_chg[0]));
    chk("frz_out",    32'(if_frz.numero_output),  32'(m_out[1]));
    chk("frz_sel",    32'(if_frz.sel_o),          32'(m_sel[1]));
    chk("frz_blank",  32'(if_frz.blank_o),        32'(m_bo[1]));
    chk("frz_chg",    32'(if_frz.changed_o),      32'(m_chg[1]));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    model_step(0, 1'b1, rst, data, valid);
    model_step(1, 1'b0, rst, data, valid);
    #1;
    check_all();
  endtask

  initial begin
    logic [63:0] r64;

    rst   = 1'b0;
    valid = 3'b000;
    data  = {16'h00FF, 16'h0034, 16'h0012};
    model_reset(0);
    model_reset(1);

    // Reset state.
    #2;
    chk("rst_out",   32'(if_live.numero_output), 32'h0);
    chk("rst_sel",   32'(if_live.sel_o),         32'h0);
    chk("rst_blank", 32'(if_live.blank_o),       32'h0);
    chk("rst_chg",   32'(if_live.changed_o),     32'h0);
    tick();
    tick();
    #2 rst = 1'b1;

    // First edge after release loads ch0.
    tick();
    chk("t1_out",     32'(if_live.numero_output), 32'h0012);
    chk("t1_sel",     32'(if_live.sel_o),         32'h0);
    chk("t1_frz_out", 32'(if_frz.numero_output),  32'h0);

    // ch1 becomes valid: two blank cycles, then ch1 shown with a change pulse.
    valid = 3'b010;
    tick();
    chk("t2_blank1", 32'(if_live.blank_o),       32'h1);
    chk("t2_zero1",  32'(if_live.numero_output), 32'h0);
    tick();
    chk("t2_blank2", 32'(if_live.blank_o),       32'h1);
    tick();
    chk("t2_out",     32'(if_live.numero_output), 32'h0034);
    chk("t2_sel",     32'(if_live.sel_o),         32'h1);
    chk("t2_chg",     32'(if_live.changed_o),     32'h1);
    chk("t2_frz_out", 32'(if_frz.numero_output),  32'h0034);

    // ch1 drops: display held until the hold expires, then back to ch0.
    valid = 3'b000;
    for (int i = 0; i < HOLD; i++) begin
      tick();
      chk("t3_hold_out", 32'(if_live.numero_output), 32'h0034);
      chk("t3_hold_chg", 32'(if_live.changed_o),     32'h0);
    end
    tick();
    chk("t3_blank1", 32'(if_live.blank_o), 32'h1);
    tick();
    chk("t3_blank2", 32'(if_live.blank_o), 32'h1);
    tick();
    chk("t3_out", 32'(if_live.numero_output), 32'h0012);
    chk("t3_sel", 32'(if_live.sel_o),         32'h0);

    // ch1 and ch2 together: one switch straight to ch2.
    valid = 3'b110;
    tick();
    chk("t4_blank_sel", 32'(if_live.sel_o), 32'h2);
    tick();
    tick();
    chk("t4_out", 32'(if_live.numero_output), 32'h00FF);
    chk("t4_sel", 32'(if_live.sel_o),         32'h2);
    chk("t4_chg", 32'(if_live.changed_o),     32'h1);

    // Drop back toward ch0 and reset in the second blank cycle.
    valid = 3'b000;
    repeat (HOLD) tick();
    tick();
    chk("t5_blank1", 32'(if_live.blank_o), 32'h1);
    tick();
    chk("t5_blank2", 32'(if_live.blank_o), 32'h1);
    #2 rst = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    chk("t5_async_out",   32'(if_live.numero_output), 32'h0);
    chk("t5_async_sel",   32'(if_live.sel_o),         32'h0);
    chk("t5_async_blank", 32'(if_live.blank_o),       32'h0);
    check_all();
    tick();
    #2 rst = 1'b1;
    tick();
    chk("t5_post_out", 32'(if_live.numero_output), 32'h0012);
    chk("t5_post_chg", 32'(if_live.changed_o),     32'h0);
    tick();
    chk("t5_post_chg2", 32'(if_live.changed_o), 32'h0);

    // Frozen instance keeps the value captured at SHOW entry.
    valid = 3'b010;
    repeat (3) tick();
    chk("t6_frz_entry", 32'(if_frz.numero_output), 32'h0034);
    data[31:16] = 16'h0099;
    repeat (3) tick();
    chk("t6_frz_out",  32'(if_frz.numero_output),  32'h0034);
    chk("t6_live_out", 32'(if_live.numero_output), 32'h0099);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (!rst) begin
        rst = 1'b1;
      end else if ($urandom_range(199) == 0) begin
        rst = 1'b0;
      end
      if ($urandom_range(3) == 0) valid = 3'($urandom_range(7));
      if ($urandom_range(1) == 0) begin
        r64  = {$urandom(), $urandom()};
        data = r64[47:0];
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
